vending_machine: RTL and testbench

//  Coin-operated vending controller for a 4-item board-level machine. Accepts 5c/10c/25c coin

---
 rtl/vending_pkg.sv | 17 +
 rtl/vending_machine_bin2bcd.sv | 36 +++
 rtl/vending_machine.sv | 136 +++++++++++++
 tb/tb_vending_machine.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared types and constants for the vending controller.
// Optional build macro: VEND_ERR_EN (error-flash state).
package vending_pkg;

  localparam int CREDIT_W = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    VEND = 2'd1,
    ERR  = 2'd2
  } state_t;

  localparam logic [CREDIT_W-1:0] COIN5  = 10'd5;
  localparam logic [CREDIT_W-1:0] COIN10 = 10'd10;
  localparam logic [CREDIT_W-1:0] COIN25 = 10'd25;

endpackage

// File: rtl/vending_machine_bin2bcd.sv
// Combinational 10-bit binary to 4-digit BCD (double-dabble).
// Optional build macro: VEND_ERR_EN (not used in this file).
module bin2bcd
  import vending_pkg::*;
(
  input  logic [CREDIT_W-1:0] i_bin,
  output logic [3:0]          o_d1,
  output logic [3:0]          o_d2,
  output logic [3:0]          o_d3,
  output logic [3:0]          o_d4
);

  localparam int SH_W = 16 + CREDIT_W;

  logic [SH_W-1:0] w_sh;

  // Shift-add-3: adjust each BCD nibble before every shift.
  always_comb begin
    w_sh = '0;
    w_sh[CREDIT_W-1:0] = i_bin;
    for (int i = 0; i < CREDIT_W; i++) begin
      for (int d = 0; d < 4; d++) begin
        if (w_sh[CREDIT_W+4*d +: 4] >= 4'd5)
          w_sh[CREDIT_W+4*d +: 4] =
            w_sh[CREDIT_W+4*d +: 4] + 4'd3;
      end
      w_sh = w_sh << 1;
    end
  end

  assign o_d1 = w_sh[CREDIT_W+0  +: 4];
  assign o_d2 = w_sh[CREDIT_W+4  +: 4];
  assign o_d3 = w_sh[CREDIT_W+8  +: 4];
  assign o_d4 = w_sh[CREDIT_W+12 +: 4];

endmodule

// File: rtl/vending_machine.sv
// Coin-operated 4-item vending controller with BCD credit display.
// Optional build macro: VEND_ERR_EN (failed purchase flashes all LEDs).
module vending_machine
  import vending_pkg::*;
#(
  parameter int PRICE0     = 15,
  parameter int PRICE1     = 20,
  parameter int PRICE2     = 25,
  parameter int PRICE3     = 30,
  parameter int CREDIT_MAX = 995,
  parameter int LED_HOLD   = 8
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [2:0] btn,
  input  logic [3:0] sw,
  output logic [3:0] disp_dig1,
  output logic [3:0] disp_dig2,
  output logic [3:0] disp_dig3,
  output logic [3:0] disp_dig4,
  output logic [3:0] leds
);

  localparam int CNT_W = $clog2(LED_HOLD + 1);

  logic [2:0]          r_btn_s1;
  logic [2:0]          r_btn_s2;
  logic [3:0]          r_sw_s1;
  logic [3:0]          r_sw_s2;
  logic [CREDIT_W-1:0] r_credit;
  logic [CNT_W-1:0]    r_cnt;
  state_t              r_state;

  logic [2:0]          w_btn_p;
  logic [3:0]          w_sw_p;
  logic                w_coin_hit;
  logic [CREDIT_W-1:0] w_coin_val;
  logic [CREDIT_W:0]   w_sum;
  logic                w_coin_ok;
  logic                w_buy_hit;
  logic [3:0]          w_buy_1h;
  logic [CREDIT_W-1:0] w_price;
  logic                w_buy_ok;

  assign w_btn_p = r_btn_s1 & ~r_btn_s2;
  assign w_sw_p  = r_sw_s1 & ~r_sw_s2;

  // Highest-value coin wins when several pulse together.
  always_comb begin
    w_coin_hit = 1'b1;
    w_coin_val = '0;
    if (w_btn_p[2])      w_coin_val = COIN25;
    else if (w_btn_p[1]) w_coin_val = COIN10;
    else if (w_btn_p[0]) w_coin_val = COIN5;
    else                 w_coin_hit = 1'b0;
  end

  assign w_sum = {1'b0, r_credit} + {1'b0, w_coin_val};
  assign w_coin_ok = w_coin_hit &&
    (w_sum <= (CREDIT_W+1)'(CREDIT_MAX));

  // Lowest-index selection wins; a coin in the same cycle drops it.
  always_comb begin
    w_buy_1h = 4'b0000;
    w_price  = '0;
    if (w_sw_p[0]) begin
      w_buy_1h = 4'b0001;
      w_price  = CREDIT_W'(PRICE0);
    end else if (w_sw_p[1]) begin
      w_buy_1h = 4'b0010;
      w_price  = CREDIT_W'(PRICE1);
    end else if (w_sw_p[2]) begin
      w_buy_1h = 4'b0100;
      w_price  = CREDIT_W'(PRICE2);
    end else if (w_sw_p[3]) begin
      w_buy_1h = 4'b1000;
      w_price  = CREDIT_W'(PRICE3);
    end
  end

  assign w_buy_hit = (|w_sw_p) && !w_coin_hit;
  assign w_buy_ok  = w_buy_hit && (r_credit >= w_price);

  // Input sync, credit register, LED FSM and hold counter.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_credit <= '0;
      r_cnt    <= '0;
      r_state  <= IDLE;
      leds     <= 4'b0000;
    end else begin
      r_btn_s1 <= btn;
      r_btn_s2 <= r_btn_s1;
      r_sw_s1  <= sw;
      r_sw_s2  <= r_sw_s1;

      if (w_coin_ok)
        r_credit <= w_sum[CREDIT_W-1:0];
      else if (w_buy_ok)
        r_credit <= r_credit - w_price;

      if (w_buy_ok) begin
        leds    <= w_buy_1h;
        r_cnt   <= CNT_W'(LED_HOLD);
        r_state <= VEND;
`ifdef VEND_ERR_EN
      end else if (w_buy_hit) begin
        leds    <= 4'b1111;
        r_cnt   <= CNT_W'(LED_HOLD);
        r_state <= ERR;
`endif
      end else if (r_state != IDLE) begin
        if (r_cnt <= CNT_W'(1)) begin
          leds    <= 4'b0000;
          r_cnt   <= '0;
          r_state <= IDLE;
        end else begin
          r_cnt <= r_cnt - CNT_W'(1);
        end
      end
    end
  end

  bin2bcd u_bcd (
    .i_bin (r_credit),
    .o_d1  (disp_dig1),
    .o_d2  (disp_dig2),
    .o_d3  (disp_dig3),
    .o_d4  (disp_dig4)
  );

endmodule

// File: tb/tb_vending_machine.sv
// Scoreboard bench for vending_machine.
// Optional build macro: VEND_ERR_EN (switches failed-purchase expectations).
module tb_vending_machine;

  logic       clk = 1'b0;
  logic       clr;
  logic [2:0] btn;
  logic [3:0] sw;
  logic [3:0] d1, d2, d3, d4;
  logic [3:0] leds;

  typedef struct {
    int         cyc;
    int         credit;
    logic [3:0] leds;
    string      name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  vending_machine dut (
    .clk       (clk),
    .clr       (clr),
    .btn       (btn),
    .sw        (sw),
    .disp_dig1 (d1),
    .disp_dig2 (d2),
    .disp_dig3 (d3),
    .disp_dig4 (d4),
    .leds      (leds)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] bcd(int v);
    return {4'(v / 1000), 4'((v / 100) % 10),
            4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Monitor: compare every expectation due at this cycle.
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == cyc) begin
        logic [15:0] got_d;
        logic [15:0] exp_d;
        got_d = {d4, d3, d2, d1};
        exp_d = bcd(q[i].credit);
        n_chk++;
        if (got_d === exp_d && leds === q[i].leds)
          n_pass++;
        else
          $display("FAIL %s cyc=%0d digits=%h leds=%b expected digits=%h leds=%b",
                   q[i].name, cyc, got_d, leds, exp_d, q[i].leds);
        q.delete(i);
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_at(int d, int cr, logic [3:0] l, string nm);
    exp_t e;
    e.cyc = cyc + d;
    e.credit = cr;
    e.leds = l;
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic press(logic [2:0] b, logic [3:0] s, int hold, int gap,
                       int cr, logic [3:0] l, string nm);
    btn = b;
    sw = s;
    expect_at(2, cr, l, nm);
    step(hold);
    btn = '0;
    sw = '0;
    step(gap);
  endtask

  initial begin
    int cr;
    clr = 1'b0;
    btn = '0;
    sw = '0;
    @(negedge clk);

    clr = 1'b1;
    expect_at(1, 0, 4'b0000, "reset");
    step(2);
    clr = 1'b0;
    step(1);

    press(3'b001, 4'b0000, 1, 3, 5, 4'b0000, "coin5");

`ifdef VEND_ERR_EN
    expect_at(9, 5, 4'b1111, "err_hold");
    expect_at(10, 5, 4'b0000, "err_end");
    press(3'b000, 4'b0001, 1, 12, 5, 4'b1111, "buy_fail");
`else
    expect_at(6, 5, 4'b0000, "fail_quiet");
    press(3'b000, 4'b0001, 1, 12, 5, 4'b0000, "buy_fail");
`endif

    press(3'b010, 4'b0000, 1, 3, 15, 4'b0000, "coin10");
    expect_at(9, 0, 4'b0001, "vend_hold");
    expect_at(10, 0, 4'b0000, "vend_end");
    press(3'b000, 4'b0001, 1, 12, 0, 4'b0001, "buy0");

    press(3'b100, 4'b0000, 1, 3, 25, 4'b0000, "c25a");
    press(3'b100, 4'b0000, 1, 3, 50, 4'b0000, "c25b");
    press(3'b000, 4'b0100, 1, 12, 25, 4'b0100, "buy2");

    cr = 25;
    for (int i = 0; i < 38; i++) begin
      cr += 25;
      press(3'b100, 4'b0000, 1, 1, cr, 4'b0000, "fill");
    end
    press(3'b010, 4'b0000, 1, 3, 985, 4'b0000, "fill10");
    press(3'b001, 4'b0000, 1, 3, 990, 4'b0000, "fill5");
    press(3'b100, 4'b0000, 1, 3, 990, 4'b0000, "reject25");
    press(3'b001, 4'b0000, 1, 3, 995, 4'b0000, "c5_to_max");
    press(3'b001, 4'b0000, 1, 3, 995, 4'b0000, "reject5_max");

    press(3'b000, 4'b1000, 1, 3, 965, 4'b1000, "buy3");
    press(3'b010, 4'b0000, 1, 12, 975, 4'b1000, "coin_in_vend");
    press(3'b011, 4'b0000, 1, 3, 985, 4'b0000, "multi_coin");

    expect_at(19, 965, 4'b0000, "held_single");
    press(3'b000, 4'b0010, 20, 12, 965, 4'b0010, "buy1_held");

    press(3'b001, 4'b0001, 1, 3, 970, 4'b0000, "coin_wins");

    press(3'b000, 4'b0110, 1, 2, 950, 4'b0010, "lowest_idx");
    expect_at(9, 935, 4'b0001, "reload");
    expect_at(10, 935, 4'b0000, "reload_end");
    press(3'b000, 4'b0001, 1, 1, 935, 4'b0001, "replace");
    step(10);

    press(3'b000, 4'b0001, 1, 1, 920, 4'b0001, "buy0b");
    clr = 1'b1;
    btn = 3'b001;
    expect_at(1, 0, 4'b0000, "clr_mid_vend");
    step(2);
    clr = 1'b0;
    expect_at(2, 5, 4'b0000, "held_thru_clr");
    expect_at(6, 5, 4'b0000, "held_no_repeat");
    step(8);
    btn = '0;
    step(3);

    for (int i = 0; i < 50 && q.size() > 0; i++)
      step(1);
    if (q.size() > 0) begin
      $display("FAIL timeout pending=%0d expected pending=0", q.size());
      n_chk += q.size();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
